// File: rtl/ds_cmd_pkg.sv
// Shared definitions for the data-strobe command link (tx and rx).
// Parity bit per frame is enabled by the DS_CMD_TX_PARITY_EN macro.
package ds_cmd_pkg;

    localparam int CMD_W = 8;

`ifdef DS_CMD_TX_PARITY_EN
    localparam int NBITS = CMD_W + 1;
`else
    localparam int NBITS = CMD_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } ds_tx_state_t;

    // Bit that makes the total number of ones odd.
    function automatic logic odd_parity(input logic [CMD_W-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ds_cmd_tx_if.sv
// Valid/ready byte handshake into the DS command transmitter.
interface ds_cmd_tx_if;
    import ds_cmd_pkg::*;

    logic [CMD_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ds_bit_tick.sv
// Bit-period counter: bit_end marks the last cycle of each serial bit.
module ds_bit_tick #(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic bit_end
);

    localparam logic [15:0] DIV_M1 = 16'(BIT_DIV - 1);

    logic [15:0] cnt;

    assign bit_end = en && (cnt == DIV_M1);

    // Loading the terminal count makes the first boundary land one
    // cycle after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= DIV_M1;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ds_cmd_tx.sv
// DS command transmitter: serialises bytes MSB-first on data/strobe.
// Optional odd parity bit via DS_CMD_TX_PARITY_EN.
module ds_cmd_tx
    import ds_cmd_pkg::*;
#(
    parameter int BIT_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    ds_cmd_tx_if.slave        cmd,
    output logic              data_out,
    output logic              strobe_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    localparam logic [15:0] GAP_M1  = 16'(GAP_CYC - 1);
    localparam logic [3:0]  LAST_IX = 4'(NBITS - 1);

    ds_tx_state_t     state, state_nxt;
    logic [NBITS-1:0] sh;
    logic [NBITS-1:0] cap;
    logic [3:0]       idx;
    logic [15:0]      gap_cnt, gap_nxt;
    logic             first;
    logic             bit_end;
    logic             take;
    logic             emit;
    logic             last_bit;
    logic             done_nxt;

    assign cmd.in_ready = (state == IDLE) && !rst;
    assign busy         = (state != IDLE);
    assign take         = cmd.in_valid && cmd.in_ready;
    assign last_bit     = (idx == LAST_IX);
    assign emit         = (state == SEND) && bit_end && (first || !last_bit);

`ifdef DS_CMD_TX_PARITY_EN
    assign cap = {cmd.in_data, odd_parity(cmd.in_data)};
`else
    assign cap = cmd.in_data;
`endif

    ds_bit_tick #(
        .BIT_DIV (BIT_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .load    (take),
        .en      (state == SEND),
        .bit_end (bit_end)
    );

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        unique case (state)
            IDLE: if (take) state_nxt = SEND;
            SEND: begin
                if (bit_end && !first && last_bit) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_M1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else gap_nxt = gap_cnt - 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == GAP) && (gap_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= '0;
            idx        <= '0;
            first      <= 1'b0;
            gap_cnt    <= '0;
            data_out   <= 1'b0;
            strobe_out <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            done    <= done_nxt;
            if (take) begin
                sh    <= cap;
                idx   <= '0;
                first <= 1'b1;
            end else if (emit) begin
                data_out <= sh[NBITS-1];
                // Strobe carries the edge whenever data does not.
                if (sh[NBITS-1] == data_out) strobe_out <= ~strobe_out;
                sh    <= sh << 1;
                first <= 1'b0;
                if (!first) idx <= idx + 4'd1;
            end
            if (state == GAP && gap_cnt == '0) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: doc/ds_cmd_tx.md
# ds_cmd_tx

Data-strobe command transmitter. It accepts 8-bit command bytes over a valid/ready handshake and serialises them MSB-first onto a data/strobe line pair. It is the transmit end of the link whose receive side is `cmd_gen`: its `data_out`/`strobe_out` connect directly to `cmd_gen`'s `data_in`/`strobe_in`. It replaces hand-written stimulus tasks in benches and drives the link in loopback builds.

## Interface
- `BIT_DIV`, default 4: clock cycles per serial bit. Legal range is 2..65535.
- `GAP_CYC`, default 8: minimum quiet cycles after the last bit before the next frame may start. Legal range is 1..65535.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  8: command byte to send.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block can accept a byte.
- `data_out`  out  1: DS data line.
- `strobe_out`  out  1: DS strobe line.
- `busy`  out  1: a frame or the post-frame gap is in progress.
- `done`  out  1: one-cycle pulse in the last cycle of the gap.
- `frame_cnt`  out  16: number of frames completed.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SEND: shifts bits out.
  - GAP: counts down `GAP_CYC` cycles.
- Transitions:
  - IDLE→SEND on `in_valid && in_ready`; `in_data` is captured into the shift register on that edge.
  - SEND→GAP after the last bit has been held for `BIT_DIV` cycles.
  - GAP→IDLE after `GAP_CYC` cycles; `done` pulses in the final GAP cycle and `frame_cnt` increments on that same edge.
- DS encoding, applied at each bit boundary:
  - `data_out` takes the new bit value.
  - `strobe_out` toggles if and only if the new bit equals the previous `data_out`.
  - Exactly one line changes per bit.
- Lines keep their last values between frames; they do not return to 0. A receiver detects a frame start as the first line transition after quiet.
- Frame length is NBITS = 8, or 9 with parity enabled.
- Counters:
  - The bit-period counter is 16 bits and counts 0..BIT_DIV-1.
  - The bit index counts 0..NBITS-1.
  - The gap counter is 16 bits.
  - `frame_cnt` wraps 0xFFFF→0x0000 without any flag.
- `in_valid` while not in IDLE is ignored; the byte is not consumed and upstream must hold it.
- `busy` = (state != IDLE).
- Reset values: state IDLE, `data_out`=0, `strobe_out`=0, `in_ready`=0 while `rst` is high, `busy`=0, `done`=0, `frame_cnt`=0, shift register 0.
- Reset mid-frame abandons the frame: both lines are 0 on the edge where `rst` is sampled, and `frame_cnt` does not increment.

## Timing
- Handshake at edge T → the first bit appears on the lines at edge T+1, i.e. latency is one cycle.
- Each bit is stable for exactly `BIT_DIV` cycles.
- `in_ready` re-asserts at T+1+NBITS·BIT_DIV+GAP_CYC. This gives a back-to-back throughput of one byte per NBITS·BIT_DIV+GAP_CYC+1 cycles.
- `in_ready` is 1 in the first cycle after `rst` deasserts.
- All outputs are registered except `in_ready` and `busy`, which decode state combinationally (and `in_ready` is gated by `rst`).

## Configuration
- `DS_CMD_TX_PARITY_EN`
  - Defined: a ninth bit is appended after the LSB. It carries odd parity, so the total number of ones across the 9 bits is odd. NBITS=9.
  - Undefined: 8 bits per frame; no parity logic is synthesised.

## Structure
- Package `ds_cmd_pkg` holds:
  - `CMD_W`=8.
  - `ds_tx_state_t` enum {IDLE, SEND, GAP}.
  - `NBITS` constant, derived from the macro.
  - `odd_parity()` function.
  - These are shared with the receive side.
- One sub-module, `ds_bit_tick`: the `BIT_DIV` period counter. It produces a `bit_end` pulse and is restarted by `load`.
- The top level holds the FSM, the shift register, the DS encoder and the counters.

## Test plan
- Reset, then send 0xA5 with BIT_DIV=4 and parity off:
  - Lines from (d,s)=(0,0) step through (1,0)(0,0)(1,0)(0,0)(0,1)(1,1)(0,1)(1,1), each held 4 cycles.
  - `done` pulses once and `frame_cnt`=1.
- Same byte with `DS_CMD_TX_PARITY_EN`:
  - A ninth bit=1 follows; final lines are (1,0).
  - `in_ready` returns 45 cycles after the handshake.
- Send 0x00 from (0,0):
  - `data_out` stays 0.
  - `strobe_out` toggles 8 times and ends at 0.
- Back-to-back bytes 0xFF, 0x3C with `in_valid` held high:
  - The second handshake occurs in the first cycle `in_ready`=1.
  - No overlap with the first frame.
  - Gap ≥ `GAP_CYC` with no line transitions.
- Assert `rst` during bit 3 of a frame:
  - Lines are 0, `busy`=0 and `frame_cnt` is unchanged in the cycle after reset is sampled.
  - The next byte transmits cleanly.
- Preload so that `frame_cnt`=0xFFFF and send one byte: `frame_cnt` wraps to 0x0000.
